regfile_wb_scheduler: RTL and testbench

Writeback scheduler and hazard scoreboard for the 32-entry register file. Arbitrates the ALU and load-unit writeback streams onto the register file's single write port, drives that port through a registered stage, and tracks per-register pending writes. Decode stalls on any RAW or WAW hazard until the producing write has landed. Sits between Decode, the execute and memory units, and the register file.

---
 rtl/regfile_wb_scheduler_if.sv | 46 ++++
 rtl/regfile_wb_scheduler.sv | 109 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of decode issue, ALU/load writeback and register-file write-port signals
// shared by the writeback scheduler and the blocks around it.
interface regfile_wb_scheduler_if #(
  parameter int num_reg    = 32,
  parameter int data_width = 32,
  parameter int idx_width  = $clog2(num_reg)
);
  logic                  issue_valid;
  logic [idx_width-1:0]  issue_rs1;
  logic [idx_width-1:0]  issue_rs2;
  logic [idx_width-1:0]  issue_rd;
  logic                  issue_uses_rs1;
  logic                  issue_uses_rs2;
  logic                  issue_writes_rd;
  logic                  issue_ready;

  logic                  alu_valid;
  logic [idx_width-1:0]  alu_rd;
  logic [data_width-1:0] alu_data;
  logic                  alu_ready;

  logic                  mem_valid;
  logic [idx_width-1:0]  mem_rd;
  logic [data_width-1:0] mem_data;
  logic                  mem_ready;

  logic                  WEn;
  logic [idx_width-1:0]  rd;
  logic [data_width-1:0] rdv;
  logic [num_reg-1:0]    pending;
  logic                  wb_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
           issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
           alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  issue_ready, alu_ready, mem_ready, WEn, rd, rdv, pending, wb_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
           issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
           alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output issue_ready, alu_ready, mem_ready, WEn, rd, rdv, pending, wb_err
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin ALU/load writeback arbiter with a registered register-file write
// stage and a per-register pending scoreboard that stalls decode on RAW/WAW.
module regfile_wb_scheduler #(
  parameter int num_reg    = 32,
  parameter int data_width = 32,
  parameter int idx_width  = $clog2(num_reg)
) (
  input logic                    clk,
  input logic                    rst,
  regfile_wb_scheduler_if.slave  bus
);

  typedef enum logic {PRI_ALU, PRI_MEM} rr_t;

  rr_t                   rr_q, rr_d;
  logic [num_reg-1:0]    pending_q;
  logic [num_reg-1:0]    set_mask;
  logic [num_reg-1:0]    clr_mask;
  logic                  wen_q;
  logic [idx_width-1:0]  rd_q;
  logic [data_width-1:0] rdv_q;
  logic                  err_q;

  logic                  issue_ok;
  logic                  issue_fire;
  logic                  alu_grant;
  logic                  mem_grant;
  logic                  grant;
  logic [idx_width-1:0]  grant_rd;
  logic [data_width-1:0] grant_data;

  // Hazard check sees only registered pending bits; no same-cycle bypass.
  always_comb begin
    issue_ok = !rst;
    if (bus.issue_uses_rs1 && pending_q[bus.issue_rs1]) issue_ok = 1'b0;
    if (bus.issue_uses_rs2 && pending_q[bus.issue_rs2]) issue_ok = 1'b0;
    if (bus.issue_writes_rd && pending_q[bus.issue_rd]) issue_ok = 1'b0;
  end

  assign issue_fire = bus.issue_valid && issue_ok;

  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    rr_d      = rr_q;
    if (!rst) begin
      if (bus.alu_valid && bus.mem_valid) begin
        if (rr_q == PRI_ALU) begin
          alu_grant = 1'b1;
          rr_d      = PRI_MEM;
        end else begin
          mem_grant = 1'b1;
          rr_d      = PRI_ALU;
        end
      end else begin
        alu_grant = bus.alu_valid;
        mem_grant = bus.mem_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= PRI_ALU;
    else     rr_q <= rr_d;
  end

  assign grant      = alu_grant || mem_grant;
  assign grant_rd   = alu_grant ? bus.alu_rd   : bus.mem_rd;
  assign grant_data = alu_grant ? bus.alu_data : bus.mem_data;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_fire && bus.issue_writes_rd && (bus.issue_rd != '0))
      set_mask[bus.issue_rd] = 1'b1;
    if (wen_q)
      clr_mask[rd_q] = 1'b1;
  end

  // Clear is applied after set so a same-index collision resolves to clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      wen_q     <= 1'b0;
      rd_q      <= '0;
      rdv_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= (pending_q | set_mask) & ~clr_mask;
      wen_q     <= grant && (grant_rd != '0);
      if (grant) begin
        rd_q  <= grant_rd;
        rdv_q <= grant_data;
      end
      if (grant && (grant_rd != '0) && !pending_q[grant_rd])
        err_q <= 1'b1;
    end
  end

  assign bus.issue_ready = issue_ok;
  assign bus.alu_ready   = alu_grant;
  assign bus.mem_ready   = mem_grant;
  assign bus.WEn         = wen_q;
  assign bus.rd          = rd_q;
  assign bus.rdv         = rdv_q;
  assign bus.pending     = pending_q;
  assign bus.wb_err      = err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench: expected register-file writes are queued at grant time and
// popped by an independent monitor whenever WEn is presented.
module tb_regfile_wb_scheduler;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  wr_t  exp_q[$];

  regfile_wb_scheduler_if #(.num_reg(32), .data_width(32), .idx_width(5)) bus ();

  regfile_wb_scheduler #(.num_reg(32), .data_width(32), .idx_width(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.issue_valid     = 1'b0;
    bus.issue_rs1       = '0;
    bus.issue_rs2       = '0;
    bus.issue_rd        = '0;
    bus.issue_uses_rs1  = 1'b0;
    bus.issue_uses_rs2  = 1'b0;
    bus.issue_writes_rd = 1'b0;
    bus.alu_valid       = 1'b0;
    bus.alu_rd          = '0;
    bus.alu_data        = '0;
    bus.mem_valid       = 1'b0;
    bus.mem_rd          = '0;
    bus.mem_data        = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic issue_wr(input logic [4:0] idx);
    bus.issue_valid     = 1'b1;
    bus.issue_uses_rs1  = 1'b0;
    bus.issue_uses_rs2  = 1'b0;
    bus.issue_writes_rd = 1'b1;
    bus.issue_rd        = idx;
  endtask

  // Monitor: every presented write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.WEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual rd=%0d rdv=%0h required no write", bus.rd, bus.rdv);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 32'(bus.rd), 32'(e.rd));
        chk("wb_rdv", bus.rdv, e.data);
      end
    end
  end

  logic [4:0]  rr_alu_rd [4] = '{5'd1, 5'd3, 5'd3, 5'd6};
  logic [4:0]  rr_mem_rd [4] = '{5'd2, 5'd2, 5'd4, 5'd4};

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clear_inputs();

    // Reset with both requesters and an issue present
    bus.alu_valid   = 1'b1;
    bus.alu_rd      = 5'd1;
    bus.mem_valid   = 1'b1;
    bus.mem_rd      = 5'd2;
    bus.issue_valid = 1'b1;
    tick();
    tick();
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_issue_ready", 32'(bus.issue_ready), 32'd0);
    chk("rst_wen", 32'(bus.WEn), 32'd0);
    chk("rst_rd", 32'(bus.rd), 32'd0);
    chk("rst_rdv", bus.rdv, 32'd0);
    chk("rst_pending", bus.pending, 32'd0);
    chk("rst_wb_err", 32'(bus.wb_err), 32'd0);

    rst = 1'b0;
    bus.issue_valid = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.alu_rd      = 5'd5;
    bus.alu_data    = 32'hDEAD_BEEF;
    #1;
    chk("post_rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("post_rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    exp_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
    tick();
    bus.alu_valid = 1'b0;
    tick();
    chk("unpending_wb_err", 32'(bus.wb_err), 32'd1);

    // RAW stall released two cycles after the load grant
    do_reset();
    issue_wr(5'd3);
    #1;
    chk("raw_first_issue_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    bus.issue_writes_rd = 1'b0;
    bus.issue_rd        = 5'd0;
    bus.issue_uses_rs1  = 1'b1;
    bus.issue_rs1       = 5'd3;
    bus.mem_valid       = 1'b1;
    bus.mem_rd          = 5'd3;
    bus.mem_data        = 32'h1234_5678;
    #1;
    chk("raw_pending_set", bus.pending, 32'h0000_0008);
    chk("raw_stall_n", 32'(bus.issue_ready), 32'd0);
    chk("raw_mem_ready", 32'(bus.mem_ready), 32'd1);
    chk("raw_alu_ready", 32'(bus.alu_ready), 32'd0);
    exp_q.push_back('{rd: 5'd3, data: 32'h1234_5678});
    tick();
    bus.mem_valid = 1'b0;
    #1;
    chk("raw_stall_n1", 32'(bus.issue_ready), 32'd0);
    chk("raw_pending_n1", bus.pending, 32'h0000_0008);
    tick();
    chk("raw_release_n2", 32'(bus.issue_ready), 32'd1);
    chk("raw_pending_n2", bus.pending, 32'd0);
    chk("hold_rd", 32'(bus.rd), 32'd3);
    chk("hold_rdv", bus.rdv, 32'h1234_5678);
    chk("raw_wen_n2", 32'(bus.WEn), 32'd0);
    chk("raw_wb_err", 32'(bus.wb_err), 32'd0);
    bus.issue_valid    = 1'b0;
    bus.issue_uses_rs1 = 1'b0;

    // Round-robin with both streams requesting for four cycles
    for (int i = 1; i <= 4; i++) begin
      tick();
      issue_wr(5'(i));
    end
    tick();
    bus.issue_valid = 1'b0;
    #1;
    chk("rr_pending", bus.pending, 32'h0000_001E);
    for (int k = 0; k < 4; k++) begin
      bus.alu_valid = 1'b1;
      bus.mem_valid = 1'b1;
      bus.alu_rd    = rr_alu_rd[k];
      bus.alu_data  = 32'hA000_0000 | 32'(rr_alu_rd[k]);
      bus.mem_rd    = rr_mem_rd[k];
      bus.mem_data  = 32'hB000_0000 | 32'(rr_mem_rd[k]);
      #1;
      chk("rr_alu_ready", 32'(bus.alu_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_mem_ready", 32'(bus.mem_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k % 2 == 0) exp_q.push_back('{rd: rr_alu_rd[k], data: 32'hA000_0000 | 32'(rr_alu_rd[k])});
      else            exp_q.push_back('{rd: rr_mem_rd[k], data: 32'hB000_0000 | 32'(rr_mem_rd[k])});
      tick();
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    tick();
    chk("rr_pending_clear", bus.pending, 32'd0);
    chk("rr_wb_err", 32'(bus.wb_err), 32'd0);

    // x0 as destination
    issue_wr(5'd0);
    #1;
    chk("x0_issue_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b1;
    bus.alu_rd      = 5'd0;
    bus.alu_data    = 32'hFFFF_FFFF;
    #1;
    chk("x0_pending", bus.pending, 32'd0);
    chk("x0_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    chk("x0_wen", 32'(bus.WEn), 32'd0);
    chk("x0_wb_err", 32'(bus.wb_err), 32'd0);

    // Writeback error and WAW stall
    tick();
    issue_wr(5'd9);
    #1;
    chk("waw_first_issue_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd7;
    bus.alu_data  = 32'h7777_0007;
    #1;
    chk("waw_pending", bus.pending, 32'h0000_0200);
    chk("waw_stall", 32'(bus.issue_ready), 32'd0);
    chk("err_alu_ready", 32'(bus.alu_ready), 32'd1);
    exp_q.push_back('{rd: 5'd7, data: 32'h7777_0007});
    tick();
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b0;
    #1;
    chk("err_set", 32'(bus.wb_err), 32'd1);
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd9;
    bus.mem_data  = 32'h9999_0009;
    #1;
    chk("err_sticky", 32'(bus.wb_err), 32'd1);
    chk("waw_mem_ready", 32'(bus.mem_ready), 32'd1);
    exp_q.push_back('{rd: 5'd9, data: 32'h9999_0009});
    tick();
    bus.mem_valid = 1'b0;
    tick();
    issue_wr(5'd9);
    #1;
    chk("waw_pending_clear", bus.pending, 32'd0);
    chk("waw_release", 32'(bus.issue_ready), 32'd1);
    chk("err_still_sticky", 32'(bus.wb_err), 32'd1);
    bus.issue_valid = 1'b0;

    // Reset while a write is in flight
    do_reset();
    issue_wr(5'd4);
    tick();
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b1;
    bus.alu_rd      = 5'd4;
    bus.alu_data    = 32'h4444_0004;
    #1;
    chk("midrst_pending", bus.pending, 32'h0000_0010);
    chk("midrst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("midrst_err_cleared", 32'(bus.wb_err), 32'd0);
    exp_q.push_back('{rd: 5'd4, data: 32'h4444_0004});
    tick();
    bus.alu_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_ready_in_rst", 32'(bus.alu_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_wen", 32'(bus.WEn), 32'd0);
    chk("midrst_pending_clear", bus.pending, 32'd0);
    chk("midrst_wb_err", 32'(bus.wb_err), 32'd0);
    tick();
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
